// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared slot record, colour types and helpers for the compositor.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_H_BITS  = 10;
  localparam int c_V_BITS  = 9;
  localparam int c_R_BITS  = 7;
  localparam int c_COLOR_W = 4;

  typedef struct packed {
    logic                on;
    logic [c_H_BITS-1:0] x;
    logic [c_V_BITS-1:0] y;
    logic [c_R_BITS-1:0] r;
  } slot_t;

  typedef struct packed {
    logic [c_COLOR_W-1:0] r;
    logic [c_COLOR_W-1:0] g;
    logic [c_COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t c_BLACK = '0;
  localparam rgb_t c_WHITE = '1;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_CIRCLE = 1'b1
  } hit_mode_e;

  // The ball always occupies the slot just past the last plate.
  function automatic int ball_slot(input int num_plates);
    return num_plates;
  endfunction

  function automatic rgb_t unpack_rgb(input logic [3*c_COLOR_W-1:0] v);
    return rgb_t'(v);
  endfunction

  function automatic logic [3*c_COLOR_W-1:0] pack_rgb(input rgb_t c);
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_obj_hit.sv
`default_nettype none
// ============================================================================
// Module   : vga_obj_hit
// Brief    : Two-stage hit test of one object slot (square plate or round ball).
// Revision : 1.0 - initial release
// ============================================================================
module vga_obj_hit
  import vga_pkg::*;
#(
  parameter int H_BITS = c_H_BITS,
  parameter int V_BITS = c_V_BITS,
  parameter int R_BITS = c_R_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  hit_mode_e         mode,
  input  logic              on,
  input  logic [H_BITS-1:0] x,
  input  logic [V_BITS-1:0] y,
  input  logic [R_BITS-1:0] r,
  input  logic [H_BITS-1:0] hcnt,
  input  logic [V_BITS-1:0] vcnt,
  output logic              hit
);

  localparam int c_D_W  = ((H_BITS > V_BITS) ? H_BITS : V_BITS) + 1;
  localparam int c_SQ_W = 2 * c_D_W;

  logic signed [c_D_W-1:0]  w_dx, w_dy, w_adx, w_ady;
  logic                     w_sq_hit;
  logic signed [c_D_W-1:0]  r_dx, r_dy;
  logic [R_BITS-1:0]        r_r;
  logic                     r_on, r_sq_hit, r_hit;
  logic signed [c_SQ_W-1:0] w_dx_ext, w_dy_ext;
  logic [c_SQ_W-1:0]        w_dx2, w_dy2;
  logic [c_SQ_W:0]          w_sum, w_r_ext, w_r2;
  logic                     w_circ_hit;

  // Zero-extend then subtract so objects hanging off any screen edge never wrap.
  assign w_dx     = $signed(c_D_W'(hcnt)) - $signed(c_D_W'(x));
  assign w_dy     = $signed(c_D_W'(vcnt)) - $signed(c_D_W'(y));
  assign w_adx    = w_dx[c_D_W-1] ? -w_dx : w_dx;
  assign w_ady    = w_dy[c_D_W-1] ? -w_dy : w_dy;
  assign w_sq_hit = on && ($unsigned(w_adx) <= c_D_W'(r)) && ($unsigned(w_ady) <= c_D_W'(r));

  assign w_dx_ext   = c_SQ_W'(r_dx);
  assign w_dy_ext   = c_SQ_W'(r_dy);
  assign w_dx2      = $unsigned(w_dx_ext * w_dx_ext);
  assign w_dy2      = $unsigned(w_dy_ext * w_dy_ext);
  assign w_sum      = (c_SQ_W+1)'(w_dx2) + (c_SQ_W+1)'(w_dy2);
  assign w_r_ext    = (c_SQ_W+1)'(r_r);
  assign w_r2       = w_r_ext * w_r_ext;
  assign w_circ_hit = r_on && (w_sum < w_r2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_r      <= '0;
      r_on     <= 1'b0;
      r_sq_hit <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_dx     <= w_dx;
      r_dy     <= w_dy;
      r_r      <= r;
      r_on     <= on;
      r_sq_hit <= w_sq_hit;
      r_hit    <= (mode == MODE_CIRCLE) ? w_circ_hit : r_sq_hit;
    end
  end

  assign hit = r_hit;

endmodule
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : vga_layer_compositor
// Brief    : Ball/plates/overlay/background compositor with frame-atomic
//            object table and a 3-stage pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int H_BITS     = c_H_BITS,
  parameter int V_BITS     = c_V_BITS,
  parameter int NUM_PLATES = 4,
  parameter int R_BITS     = c_R_BITS,
  parameter int COLOR_W    = c_COLOR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [H_BITS-1:0]    Hcnt,
  input  logic [V_BITS-1:0]    Vcnt,
  input  logic                 obj_wr_en,
  output logic                 obj_wr_ready,
  input  logic [3:0]           obj_wr_sel,
  input  logic [H_BITS-1:0]    obj_wr_x,
  input  logic [V_BITS-1:0]    obj_wr_y,
  input  logic [R_BITS-1:0]    obj_wr_r,
  input  logic                 obj_wr_on,
  input  logic                 commit,
  output logic                 commit_pending,
  input  logic                 end_game,
  input  logic [3*COLOR_W-1:0] overlay_rgb,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  output logic [COLOR_W-1:0]   Red,
  output logic [COLOR_W-1:0]   Green,
  output logic [COLOR_W-1:0]   Blue,
  output logic                 out_valid
);

  localparam int c_BALL_SLOT = ball_slot(NUM_PLATES);
  localparam int c_NUM_SLOTS = NUM_PLATES + 1;

  slot_t                  r_shadow [c_NUM_SLOTS];
  slot_t                  r_active [c_NUM_SLOTS];
  logic                   r_commit_pending;
  logic                   w_wr_accept, w_copy;
  logic [c_NUM_SLOTS-1:0] w_hit;
  logic [3:0]             r_h1, r_v1, r_h2, r_v2;
  logic                   r_pv1, r_pv2, r_out_valid;
  rgb_t                   w_pix, r_rgb;

  assign obj_wr_ready   = !r_commit_pending;
  assign commit_pending = r_commit_pending;
  assign w_wr_accept    = obj_wr_en && !r_commit_pending;
  // A commit that coincides with an accepted write defers the copy so the write is included.
  assign w_copy         = frame_start && (r_commit_pending || (commit && !w_wr_accept));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        if (w_wr_accept && (obj_wr_sel == 4'(i))) begin
          r_shadow[i] <= '{on: obj_wr_on, x: c_H_BITS'(obj_wr_x),
                           y: c_V_BITS'(obj_wr_y), r: c_R_BITS'(obj_wr_r)};
        end
        if (w_copy) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_copy) begin
        r_commit_pending <= 1'b0;
      end else if (commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < c_NUM_SLOTS; g++) begin : g_slot
    vga_obj_hit #(
      .H_BITS (H_BITS),
      .V_BITS (V_BITS),
      .R_BITS (R_BITS)
    ) u_hit (
      .clk  (clk),
      .rst  (rst),
      .mode ((g == c_BALL_SLOT) ? MODE_CIRCLE : MODE_SQUARE),
      .on   (r_active[g].on),
      .x    (H_BITS'(r_active[g].x)),
      .y    (V_BITS'(r_active[g].y)),
      .r    (R_BITS'(r_active[g].r)),
      .hcnt (Hcnt),
      .vcnt (Vcnt),
      .hit  (w_hit[g])
    );
  end

  // Plate pattern depends only on the pixel position, so any plate hit selects it.
  always_comb begin
    w_pix = unpack_rgb(bg_rgb);
    if (end_game) begin
      w_pix = unpack_rgb(overlay_rgb);
    end else if (w_hit[c_BALL_SLOT]) begin
      w_pix = c_BLACK;
    end else if (|w_hit[NUM_PLATES-1:0]) begin
      w_pix = '{r: r_v2, g: r_h2, b: {r_h2[1:0], r_v2[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h1        <= '0;
      r_v1        <= '0;
      r_pv1       <= 1'b0;
      r_h2        <= '0;
      r_v2        <= '0;
      r_pv2       <= 1'b0;
      r_rgb       <= c_BLACK;
      r_out_valid <= 1'b0;
    end else begin
      r_h1        <= Hcnt[3:0];
      r_v1        <= Vcnt[3:0];
      r_pv1       <= pix_valid;
      r_h2        <= r_h1;
      r_v2        <= r_v1;
      r_pv2       <= r_pv1;
      r_rgb       <= r_pv2 ? w_pix : c_BLACK;
      r_out_valid <= r_pv2;
    end
  end

  assign Red       = r_rgb.r;
  assign Green     = r_rgb.g;
  assign Blue      = r_rgb.b;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_layer_compositor
// Brief    : Directed self-checking bench for vga_layer_compositor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_layer_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  Hcnt = '0;
  logic [8:0]  Vcnt = '0;
  logic        obj_wr_en = 1'b0;
  logic        obj_wr_ready;
  logic [3:0]  obj_wr_sel = '0;
  logic [9:0]  obj_wr_x = '0;
  logic [8:0]  obj_wr_y = '0;
  logic [6:0]  obj_wr_r = '0;
  logic        obj_wr_on = 1'b0;
  logic        commit = 1'b0;
  logic        commit_pending;
  logic        end_game = 1'b0;
  logic [11:0] overlay_rgb = '0;
  logic [11:0] bg_rgb = '0;
  logic [3:0]  Red, Green, Blue;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_layer_compositor u_dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .Hcnt           (Hcnt),
    .Vcnt           (Vcnt),
    .obj_wr_en      (obj_wr_en),
    .obj_wr_ready   (obj_wr_ready),
    .obj_wr_sel     (obj_wr_sel),
    .obj_wr_x       (obj_wr_x),
    .obj_wr_y       (obj_wr_y),
    .obj_wr_r       (obj_wr_r),
    .obj_wr_on      (obj_wr_on),
    .commit         (commit),
    .commit_pending (commit_pending),
    .end_game       (end_game),
    .overlay_rgb    (overlay_rgb),
    .bg_rgb         (bg_rgb),
    .Red            (Red),
    .Green          (Green),
    .Blue           (Blue),
    .out_valid      (out_valid)
  );

  // Reference scene: active table as the bench expects it
  logic        m_on [5];
  int          m_x [5], m_y [5], m_r [5];
  logic        m_end;
  logic [11:0] m_bg;
  int          hh [3], hv [3];
  logic        hpv [3];
  bit          auto_chk = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ovl_of(input int h, input int v);
    logic [9:0] hb;
    logic [8:0] vb;
    hb = 10'(h);
    vb = 9'(v);
    return {vb[3:0] ^ 4'h5, hb[3:0], 4'hA};
  endfunction

  function automatic logic [12:0] model_px(input int h, input int v, input logic pv);
    logic [9:0] hb;
    logic [8:0] vb;
    hb = 10'(h);
    vb = 9'(v);
    if (!pv) return 13'd0;
    if (m_end) return {1'b1, ovl_of(h, v)};
    if (m_on[4] && ((h - m_x[4]) * (h - m_x[4]) + (v - m_y[4]) * (v - m_y[4]) < m_r[4] * m_r[4]))
      return {1'b1, 12'h000};
    for (int i = 0; i < 4; i++) begin
      if (m_on[i] && (h - m_x[i] <= m_r[i]) && (m_x[i] - h <= m_r[i]) &&
          (v - m_y[i] <= m_r[i]) && (m_y[i] - v <= m_r[i]))
        return {1'b1, vb[3:0], hb[3:0], hb[1:0], vb[1:0]};
    end
    return {1'b1, m_bg};
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hh[i] = 0; hv[i] = 0; hpv[i] = 1'b0;
    end
  endtask

  // One pixel per clock; overlay is supplied for the pixel now in stage 2.
  task automatic step(input int h, input int v, input logic pv);
    Hcnt        = 10'(h);
    Vcnt        = 9'(v);
    pix_valid   = pv;
    overlay_rgb = ovl_of(hh[1], hv[1]);
    hh[2] = hh[1]; hv[2] = hv[1]; hpv[2] = hpv[1];
    hh[1] = hh[0]; hv[1] = hv[0]; hpv[1] = hpv[0];
    hh[0] = h;     hv[0] = v;     hpv[0] = pv;
    @(posedge clk); #1;
    if (auto_chk)
      check($sformatf("px(%0d,%0d)", hh[2], hv[2]),
            {19'd0, out_valid, Red, Green, Blue},
            {19'd0, model_px(hh[2], hv[2], hpv[2])});
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b0);
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] exp, input string tag);
    auto_chk = 1'b0;
    repeat (3) step(h, v, 1'b1);
    check(tag, {20'd0, Red, Green, Blue}, {20'd0, exp});
    auto_chk = 1'b1;
  endtask

  task automatic wr(input int sel, input int x, input int y, input int r, input logic on);
    obj_wr_en  = 1'b1;
    obj_wr_sel = 4'(sel);
    obj_wr_x   = 10'(x);
    obj_wr_y   = 9'(y);
    obj_wr_r   = 7'(r);
    obj_wr_on  = on;
    step(0, 0, 1'b0);
    obj_wr_en  = 1'b0;
  endtask

  task automatic set_model(input int i, input int x, input int y, input int r);
    m_on[i] = 1'b1; m_x[i] = x; m_y[i] = y; m_r[i] = r;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      m_on[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_r[i] = 0;
    end
    m_end = 1'b0;
    m_bg  = 12'hFFF;
    clear_hist();

    // Reset state with a visible pixel already presented
    bg_rgb = 12'hFFF; pix_valid = 1'b1; Hcnt = 10'd5; Vcnt = 9'd5;
    repeat (4) @(posedge clk);
    #1;
    check("rst_out", {19'd0, out_valid, Red, Green, Blue}, 32'd0);
    check("rst_ready", {31'd0, obj_wr_ready}, 32'd1);
    check("rst_pending", {31'd0, commit_pending}, 32'd0);
    rst = 1'b1;

    // Latency: output appears on the third edge after pix_valid is presented
    auto_chk = 1'b0;
    step(5, 5, 1'b1); check("lat1_valid", {31'd0, out_valid}, 32'd0);
    step(5, 5, 1'b1); check("lat2_valid", {31'd0, out_valid}, 32'd0);
    step(5, 5, 1'b1); check("lat3_valid", {31'd0, out_valid}, 32'd1);
    check("lat3_rgb", {20'd0, Red, Green, Blue}, 32'hFFF);
    auto_chk = 1'b1;
    flush();

    // Plate 0, commit then frame_start
    wr(0, 300, 300, 50, 1'b1);
    commit = 1'b1; step(0, 0, 1'b0); commit = 1'b0;
    check("commit_pending_set", {31'd0, commit_pending}, 32'd1);
    frame_start = 1'b1; step(0, 0, 1'b0); frame_start = 1'b0;
    check("commit_pending_clr", {31'd0, commit_pending}, 32'd0);
    set_model(0, 300, 300, 50);
    probe(250, 300, 12'hCA8, "plate_left_edge");
    probe(249, 300, 12'hFFF, "plate_left_out");
    probe(350, 300, 12'hCE8, "plate_right_edge");
    probe(351, 300, 12'hFFF, "plate_right_out");
    for (int h = 240; h <= 360; h++) step(h, 300, 1'b1);
    flush();

    // Ball on top of the plate, commit coincident with frame_start
    wr(4, 300, 300, 20, 1'b1);
    commit = 1'b1; frame_start = 1'b1; step(0, 0, 1'b0);
    commit = 1'b0; frame_start = 1'b0;
    check("commit_fs_pending", {31'd0, commit_pending}, 32'd0);
    set_model(4, 300, 300, 20);
    probe(300, 281, 12'h000, "ball_in_top");
    probe(300, 280, 12'h8C0, "ball_strict_top");
    probe(319, 300, 12'h000, "ball_in_right");
    probe(320, 300, 12'hC00, "ball_strict_right");
    for (int v = 275; v <= 325; v++) step(300, v, 1'b1);
    flush();

    // Mid-frame commit: table frozen, writes dropped until frame_start
    wr(2, 600, 200, 10, 1'b1);
    commit = 1'b1; step(600, 200, 1'b1); commit = 1'b0;
    check("mid_pending", {31'd0, commit_pending}, 32'd1);
    check("mid_ready", {31'd0, obj_wr_ready}, 32'd0);
    wr(3, 100, 100, 20, 1'b1);
    probe(600, 200, 12'hFFF, "mid_unchanged");
    flush();
    frame_start = 1'b1; step(0, 0, 1'b0); frame_start = 1'b0;
    check("fs_pending_clr", {31'd0, commit_pending}, 32'd0);
    check("fs_ready", {31'd0, obj_wr_ready}, 32'd1);
    set_model(2, 600, 200, 10);
    probe(600, 200, 12'h880, "mid_applied");
    probe(100, 100, 12'hFFF, "dropped_write");
    flush();

    // Plate hanging off the left/top edge, then an overlapping plate
    wr(1, 10, 10, 30, 1'b1);
    commit = 1'b1; frame_start = 1'b1; step(0, 0, 1'b0);
    commit = 1'b0; frame_start = 1'b0;
    set_model(1, 10, 10, 30);
    probe(0, 10, 12'hA02, "edge_col0");
    probe(40, 10, 12'hA82, "edge_col40");
    probe(41, 10, 12'hFFF, "edge_col41");
    probe(1013, 10, 12'hFFF, "edge_nowrap");
    for (int h = 0; h <= 45; h++) step(h, 10, 1'b1);
    for (int h = 995; h <= 1023; h++) step(h, 10, 1'b1);
    flush();
    wr(3, 330, 300, 40, 1'b1);
    commit = 1'b1; frame_start = 1'b1; step(0, 0, 1'b0);
    commit = 1'b0; frame_start = 1'b0;
    set_model(3, 330, 300, 40);
    probe(340, 300, 12'hC40, "overlap");
    flush();

    // Overlay layer
    end_game = 1'b1; m_end = 1'b1;
    probe(300, 300, 12'h9CA, "overlay");
    for (int h = 290; h <= 310; h++) step(h, 300, 1'b1);
    flush();
    end_game = 1'b0; m_end = 1'b0;
    flush();

    // Asynchronous reset in the middle of a line
    for (int h = 240; h <= 258; h++) step(h, 300, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", {19'd0, out_valid, Red, Green, Blue}, 32'd0);
    check("async_rst_pending", {31'd0, commit_pending}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) m_on[i] = 1'b0;
    clear_hist();
    for (int h = 240; h <= 360; h++) step(h, 300, 1'b1);
    probe(300, 300, 12'hFFF, "post_rst_bg");
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
